// File: rtl/sseg_scan_driver_pkg.sv
// Shared glyph table and helpers for the seven-segment scan driver.
// Segment codes are active-low: bit7 = dp, bits6:0 = g..a.
package sseg_pkg;

  localparam logic [7:0] SSEG_OFF = 8'hFF;
  localparam int         DP_BIT   = 7;
  localparam int         SEG_MSB  = 6;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_to_sseg(
    input logic [3:0] nibble,
    input logic       dp
  );
    logic [7:0] g;
    g         = GLYPH[nibble];
    g[DP_BIT] = g[DP_BIT] & ~dp;
    return g;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Datapath-side and pin-side signals of the scan driver.
// master = datapath/board side, slave = the driver.
interface sseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [7:0]              sseg_out;
  logic                    frame_done;

  modport master (
    output enable, load, value_in, dp_in, blank_in,
    input  an_out, sseg_out, frame_done
  );

  modport slave (
    input  enable, load, value_in, dp_in, blank_in,
    output an_out, sseg_out, frame_done
  );

endinterface

// File: rtl/sseg_scan_driver_hex_glyph.sv
// Combinational nibble -> active-low segment code decoder.
// A dark digit keeps its decimal point.
module sseg_hex_glyph
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       dark_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = hex_to_sseg(nibble_i, dp_i);
    if (dark_i) seg_o[SEG_MSB:0] = '1;
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit common-anode display driver with
// blank time, leading-zero suppression and frame-aligned updates.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_BLANK     = 1
) (
  input logic clk,
  input logic rst_n,
  sseg_scan_driver_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         p_q, p_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         val_q, val_d, pval_q, pval_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, pdp_q, pdp_d;
  logic [NUM_DIGITS-1:0] bl_q, bl_d, pbl_q, pbl_d;
  logic                  pv_q, pv_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  fd_q, fd_d;

  logic [NUM_DIGITS-1:0] lz;
  logic                  allz;
  logic [3:0]            nib;
  logic                  dark;
  logic [7:0]            glyph;
  logic                  fe;

  // Digit i is a leading zero when it and every digit above are zero.
  always_comb begin
    lz   = '0;
    allz = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      allz  = allz & (val_q[4*i +: 4] == 4'h0);
      lz[i] = allz & (LZ_BLANK != 0);
    end
  end

  assign nib  = val_q[idx_q*4 +: 4];
  assign dark = bl_q[idx_q] | lz[idx_q];

  sseg_hex_glyph u_glyph (
    .nibble_i (nib),
    .dp_i     (dp_q[idx_q]),
    .dark_i   (dark),
    .seg_o    (glyph)
  );

  assign fe = bus.enable && (p_q == P_LAST) && (idx_q == I_LAST);

  always_comb begin
    p_d    = p_q;
    idx_d  = idx_q;
    val_d  = val_q;
    dp_d   = dp_q;
    bl_d   = bl_q;
    pval_d = pval_q;
    pdp_d  = pdp_q;
    pbl_d  = pbl_q;
    pv_d   = pv_q;
    an_d   = '1;
    seg_d  = SSEG_OFF;
    fd_d   = fe;

    if (!bus.enable) begin
      p_d   = '0;
      idx_d = '0;
    end else if (p_q == P_LAST) begin
      p_d   = '0;
      idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      p_d = p_q + 1'b1;
    end

    // Active only changes at frame end or while the scan is idle.
    if (!bus.enable || fe) begin
      if (bus.load) begin
        val_d = bus.value_in;
        dp_d  = bus.dp_in;
        bl_d  = bus.blank_in;
      end else if (pv_q) begin
        val_d = pval_q;
        dp_d  = pdp_q;
        bl_d  = pbl_q;
      end
      pv_d = 1'b0;
    end else if (bus.load) begin
      pval_d = bus.value_in;
      pdp_d  = bus.dp_in;
      pbl_d  = bus.blank_in;
      pv_d   = 1'b1;
    end

    if (bus.enable && (p_q >= P_BLANK)) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = glyph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      idx_q  <= '0;
      val_q  <= '0;
      dp_q   <= '0;
      bl_q   <= '0;
      pval_q <= '0;
      pdp_q  <= '0;
      pbl_q  <= '0;
      pv_q   <= 1'b0;
      an_q   <= '1;
      seg_q  <= SSEG_OFF;
      fd_q   <= 1'b0;
    end else begin
      p_q    <= p_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      dp_q   <= dp_d;
      bl_q   <= bl_d;
      pval_q <= pval_d;
      pdp_q  <= pdp_d;
      pbl_q  <= pbl_d;
      pv_q   <= pv_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.an_out     = an_q;
  assign bus.sseg_out   = seg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display. Generalises the single-digit hex decoder to a parametrised digit count.
- Adds refresh scanning, per-digit decimal point and blanking, optional leading-zero suppression, anti-ghosting blank time, and tear-free value updates.
- Sits between the datapath (which supplies packed hex nibbles) and the board display pins.

Parameters:
- NUM_DIGITS, 4, digits driven; legal range 1..8.
- REFRESH_DIV, 50000, clocks per digit slot; must be >= 2.
- BLANK_CYCLES, 2, clocks at the start of each slot with all anodes off; must be < REFRESH_DIV.
- LZ_BLANK, 1, 1 = suppress leading zeros; 0 = show all digits.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, 0 = display dark and scan held.
- load, in, 1, single-cycle strobe that captures value_in, dp_in and blank_in.
- value_in, in, 4*NUM_DIGITS, packed hex nibbles; digit 0 = [3:0] is least significant.
- dp_in, in, NUM_DIGITS, 1 = decimal point on for that digit.
- blank_in, in, NUM_DIGITS, 1 = force that digit dark.
- an_out, out, NUM_DIGITS, anode selects, active-low, one-hot-low when lit.
- sseg_out, out, 8, segments, active-low; bit7 = dp, bits6:0 = g..a.
- frame_done, out, 1, one-cycle pulse at the end of each full scan.

Behaviour:
- Reset values (async assert, sync release):
  - an_out = all 1s, sseg_out = 8'hFF, frame_done = 0.
  - Prescaler p = 0, digit index idx = 0.
  - Active and pending registers = 0; pending_valid = 0.
- Scan timing:
  - p counts 0..REFRESH_DIV-1.
  - When p = REFRESH_DIV-1, p wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Output registration:
  - All outputs are registered. Outputs in cycle t+1 reflect p and idx in cycle t, giving one clock of latency.
  - If p < BLANK_CYCLES: an_out = all 1s and sseg_out = 8'hFF.
  - Otherwise: an_out[idx] = 0, all other anode bits = 1, and sseg_out = glyph for digit idx.
  - Each digit is therefore lit for REFRESH_DIV-BLANK_CYCLES clocks per slot.
- Glyph table, hex value to sseg_out (dp off):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8
  - 8 = 80, 9 = 90, A = 88, B = 83, C = C6, D = A1, E = 86, F = 8E
  - When dp is set, bit7 is cleared.
- Digit blanking:
  - A digit is dark (bits6:0 all 1) if its blank bit is set.
  - If LZ_BLANK = 1, a digit is also dark when i != 0 and every nibble j >= i is zero.
  - A dark digit still shows its dp if its dp bit is set.
- Load and update (tear-free):
  - load copies the inputs into the pending registers and sets pending_valid.
  - At the frame end (p = REFRESH_DIV-1 and idx = NUM_DIGITS-1), pending is copied to active and pending_valid is cleared.
  - Display decoding only ever uses the active registers.
- Boundary conditions:
  - load in the same cycle as frame end: value_in goes directly to active, and pending_valid stays 0.
  - Back-to-back loads within one frame: the last one wins.
- frame_done: registered pulse in the cycle after the frame end; exactly one clock wide.
- enable = 0:
  - p and idx are held at 0; an_out = all 1s; sseg_out = FF; frame_done = 0.
  - Load capture still operates, and pending is transferred to active immediately.
  - On re-enable, scanning starts at digit 0 with its blank interval.
- NUM_DIGITS = 1: idx stays 0, and frame_done pulses every slot.
- Reset asserted mid-scan: all state returns to reset values immediately, and the display goes dark in the same cycle.

Decomposition:
- Package sseg_pkg holds:
  - the 16 glyph constants;
  - SSEG_OFF = 8'hFF;
  - the bit-position constants (DP_BIT = 7);
  - function hex_to_sseg(nibble, dp).
- One sub-module, sseg_hex_glyph: a combinational nibble + dp + dark -> 8-bit code decoder, instantiated once on the muxed nibble.
- Prescaler, index, load/shadow logic and leading-zero detection stay in the top level.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, LZ_BLANK=1 unless noted):
- Reset, then enable=1 with no load -> every slot shows an_out=1111 for 1 clock, then 3 clocks of an_out=1110 with sseg=C0 (digit 0); digits 1-3 have an_out 1101/1011/0111 with sseg=FF (leading-zero blanked); frame_done pulses every 16 clocks.
- load value_in=16'h12AF, dp_in=4'b0100 -> after the next frame end, per digit 0..3: sseg = 8E, 88, 24, F9.
- load value_in=16'h0050 -> digit 0 = C0, digit 1 = 92, digits 2 and 3 dark (FF); rerun with LZ_BLANK=0 -> digits 2 and 3 = C0.
- load in the exact frame-end cycle with 16'h3333, followed by a second load of 16'h4444 mid-frame -> next frame shows B0 on all digits; the frame after shows 99.
- enable dropped mid-slot at digit 2 -> next clock an_out=1111 and sseg=FF; re-enable -> first lit digit is digit 0 after 1 blank clock.
- rst_n pulsed low mid-frame for a partial cycle -> outputs go dark asynchronously; after release, the active value is 0 and frame_done does not pulse until 16 clocks later.
